// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer feeding the instruction ROM address.
// Handles start/run/done sequencing, stalls, absolute jumps, relative branches and wrap tracking.
module pc_fetch_ctrl #(
    parameter int unsigned D     = 12,
    parameter int unsigned OFF_W = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [D-1:0]     start_addr,
    input  logic             stall,
    input  logic             halt,
    input  logic             jump_abs,
    input  logic [D-1:0]     target,
    input  logic             branch_rel,
    input  logic [OFF_W-1:0] offset,
    output logic [D-1:0]     prog_ctr,
    output logic             fetch_valid,
    output logic             done,
    output logic [CNT_W-1:0] instr_count,
    output logic             wrapped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [D-1:0]     pc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             wrapped_d;

    logic [D-1:0]     offset_sx;
    logic [D-1:0]     branch_pc;
    logic [D-1:0]     inc_pc;
    logic [CNT_W-1:0] cnt_inc;
    logic             offset_neg;

    // Branch/increment datapath from the registered PC
    always_comb begin
        offset_neg = offset[OFF_W-1];
        offset_sx  = {{(D-OFF_W){offset_neg}}, offset};
        branch_pc  = D'(prog_ctr + offset_sx);
        inc_pc     = D'(prog_ctr + D'(1));
        cnt_inc    = (instr_count == {CNT_W{1'b1}}) ? instr_count : CNT_W'(instr_count + CNT_W'(1));
    end

    // Next-state and datapath update selection
    always_comb begin
        state_d   = state_q;
        pc_d      = prog_ctr;
        cnt_d     = instr_count;
        wrapped_d = wrapped;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = start_addr;
                    cnt_d     = '0;
                    wrapped_d = 1'b0;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = DONE;
                    cnt_d   = cnt_inc;
                end else if (stall) begin
                    pc_d = prog_ctr;
                end else if (jump_abs) begin
                    pc_d  = target;
                    cnt_d = cnt_inc;
                end else if (branch_rel) begin
                    pc_d  = branch_pc;
                    cnt_d = cnt_inc;
                    if ((!offset_neg && branch_pc < prog_ctr) || (offset_neg && branch_pc > prog_ctr)) begin
                        wrapped_d = 1'b1;
                    end
                end else begin
                    pc_d  = inc_pc;
                    cnt_d = cnt_inc;
                    if (prog_ctr == {D{1'b1}}) begin
                        wrapped_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prog_ctr    <= '0;
            instr_count <= '0;
            wrapped     <= 1'b0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_ctr    <= pc_d;
            instr_count <= cnt_d;
            wrapped     <= wrapped_d;
            fetch_valid <= (state_d == RUN);
            done        <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with hand-computed expectations.
module tb_pc_fetch_ctrl;

    localparam int unsigned D     = 12;
    localparam int unsigned OFF_W = 6;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [D-1:0]     start_addr;
    logic             stall;
    logic             halt;
    logic             jump_abs;
    logic [D-1:0]     target;
    logic             branch_rel;
    logic [OFF_W-1:0] offset;
    logic [D-1:0]     prog_ctr;
    logic             fetch_valid;
    logic             done;
    logic [CNT_W-1:0] instr_count;
    logic             wrapped;

    int n_chk  = 0;
    int n_pass = 0;

    pc_fetch_ctrl #(.D(D), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .stall       (stall),
        .halt        (halt),
        .jump_abs    (jump_abs),
        .target      (target),
        .branch_rel  (branch_rel),
        .offset      (offset),
        .prog_ctr    (prog_ctr),
        .fetch_valid (fetch_valid),
        .done        (done),
        .instr_count (instr_count),
        .wrapped     (wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [D-1:0] pc, input logic fv,
                             input logic dn, input logic [CNT_W-1:0] cnt, input logic wr);
        check({tag, ".pc"},   32'(prog_ctr),    32'(pc));
        check({tag, ".fv"},   32'(fetch_valid), 32'(fv));
        check({tag, ".done"}, 32'(done),        32'(dn));
        check({tag, ".cnt"},  32'(instr_count), 32'(cnt));
        check({tag, ".wrap"}, 32'(wrapped),     32'(wr));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0; halt = 1'b0;
        jump_abs = 1'b0; target = '0; branch_rel = 1'b0; offset = '0;
        #2;
        check_all("reset", 12'h000, 1'b0, 1'b0, 16'd0, 1'b0);
        step();
        rst_n = 1'b1;

        // 1: start and free run
        start = 1'b1; start_addr = 12'h010;
        step();
        start = 1'b0;
        check_all("start", 12'h010, 1'b1, 1'b0, 16'd0, 1'b0);
        repeat (3) step();
        check_all("inc3", 12'h013, 1'b1, 1'b0, 16'd3, 1'b0);

        // 2: relative branches without wrap
        branch_rel = 1'b1; offset = 6'b111100;
        step();
        check_all("br_m4", 12'h00F, 1'b1, 1'b0, 16'd4, 1'b0);
        offset = 6'd31;
        step();
        branch_rel = 1'b0;
        check_all("br_p31", 12'h02E, 1'b1, 1'b0, 16'd5, 1'b0);

        // 3: stall beats jump
        jump_abs = 1'b1; target = 12'h020;
        step();
        check_all("jmp20", 12'h020, 1'b1, 1'b0, 16'd6, 1'b0);
        stall = 1'b1; target = 12'h100;
        step();
        check_all("stall", 12'h020, 1'b1, 1'b0, 16'd6, 1'b0);
        stall = 1'b0;
        step();
        jump_abs = 1'b0;
        check_all("jmp100", 12'h100, 1'b1, 1'b0, 16'd7, 1'b0);

        // start ignored in RUN
        start = 1'b1; start_addr = 12'h300;
        step();
        start = 1'b0;
        check_all("run_start", 12'h101, 1'b1, 1'b0, 16'd8, 1'b0);

        halt = 1'b1;
        step();
        halt = 1'b0;
        check_all("halt", 12'h101, 1'b0, 1'b1, 16'd9, 1'b0);
        step();
        check_all("done_hold", 12'h101, 1'b0, 1'b1, 16'd9, 1'b0);

        // 4: wrap on increment and negative branch, cleared by start
        start = 1'b1; start_addr = 12'hFFE;
        step();
        start = 1'b0;
        check_all("st_ffe", 12'hFFE, 1'b1, 1'b0, 16'd0, 1'b0);
        step();
        check_all("inc_fff", 12'hFFF, 1'b1, 1'b0, 16'd1, 1'b0);
        step();
        check_all("inc_wrap", 12'h000, 1'b1, 1'b0, 16'd2, 1'b1);
        branch_rel = 1'b1; offset = 6'b111111;
        step();
        branch_rel = 1'b0;
        check_all("br_m1", 12'hFFF, 1'b1, 1'b0, 16'd3, 1'b1);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check_all("halt2", 12'hFFF, 1'b0, 1'b1, 16'd4, 1'b1);
        start = 1'b1; start_addr = 12'h005;
        step();
        start = 1'b0;
        check_all("st_005", 12'h005, 1'b1, 1'b0, 16'd0, 1'b0);

        // 5: halt wins over stall, restart from DONE
        halt = 1'b1; stall = 1'b1;
        step();
        halt = 1'b0; stall = 1'b0;
        check_all("halt_stall", 12'h005, 1'b0, 1'b1, 16'd1, 1'b0);
        start = 1'b1; start_addr = 12'h040;
        step();
        start = 1'b0;
        check_all("st_040", 12'h040, 1'b1, 1'b0, 16'd0, 1'b0);

        // positive branch across the top; jump alone never sets wrapped
        jump_abs = 1'b1; target = 12'hFFC;
        step();
        jump_abs = 1'b0;
        check_all("jmp_ffc", 12'hFFC, 1'b1, 1'b0, 16'd1, 1'b0);
        branch_rel = 1'b1; offset = 6'd5;
        step();
        branch_rel = 1'b0;
        check_all("br_p5_wrap", 12'h001, 1'b1, 1'b0, 16'd2, 1'b1);

        // counter saturation: 65540 more increments from 2
        repeat (65540) @(posedge clk);
        #1;
        check("cnt_sat", 32'(instr_count), 32'hFFFF);
        check("sat_fv", 32'(fetch_valid), 32'd1);

        // 6: async reset mid-run with start held
        #2;
        rst_n = 1'b0; start = 1'b1; start_addr = 12'h123;
        #1;
        check_all("async_rst", 12'h000, 1'b0, 1'b0, 16'd0, 1'b0);
        step();
        check_all("rst_held", 12'h000, 1'b0, 1'b0, 16'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        step();
        start = 1'b0;
        check_all("rel_start", 12'h123, 1'b1, 1'b0, 16'd0, 1'b0);
        step();
        check_all("rel_inc", 12'h124, 1'b1, 1'b0, 16'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
